// File: rtl/stack_port_arbiter.sv
// Control and round-robin arbitration for a four-port signed stack node.
// Drives an external LIFO through push/pop strobes and tracks its occupancy.
module stack_port_arbiter #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 15,
   parameter int CLAMP = 999
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] up,
   input  logic [WIDTH-1:0] down,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   input  logic [3:0]       dataReady,
   output logic [3:0]       ackRead,
   output logic [3:0]       requestWrite,
   input  logic [3:0]       ackWrite,
   output logic [3:0]       popGrant,
   output logic [WIDTH-1:0] topOut,
   input  logic [WIDTH-1:0] topData,
   output logic             pushEn,
   output logic [WIDTH-1:0] pushData,
   output logic             popEn,
   output logic [3:0]       count,
   output logic             full,
   output logic             empty
);

   typedef enum logic [1:0] {IDLE, PUSH, POP} state_e;
   typedef enum logic {OP_PUSH, OP_POP} op_e;

   localparam logic [3:0]              DEPTH_C = 4'(DEPTH);
   localparam logic signed [WIDTH-1:0] MAX_V   = WIDTH'(CLAMP);
   localparam logic signed [WIDTH-1:0] MIN_V   = -MAX_V;

   state_e           state;
   op_e              last_op;
   logic [1:0]       push_ptr;
   logic [1:0]       pop_ptr;
   logic [WIDTH-1:0] port_data [4];
   logic [3:0]       pop_req;
   logic             push_cand;
   logic             pop_cand;
   logic             take_push;
   logic [1:0]       push_g;
   logic [1:0]       pop_g;

   // First requester strictly after ptr, wrapping; the loop runs downwards so
   // the nearest candidate is the last assignment and wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int i = 4; i >= 1; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   function automatic logic [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] v);
      if (v > MAX_V)      saturate = MAX_V;
      else if (v < MIN_V) saturate = MIN_V;
      else                saturate = v;
   endfunction

   assign full         = (count == DEPTH_C);
   assign empty        = (count == 4'd0);
   assign requestWrite = {4{(state == IDLE) && !empty}};
   assign topOut       = topData;

   always_comb begin
      port_data[0] = up;
      port_data[1] = down;
      port_data[2] = left;
      port_data[3] = right;
   end

   // NOTE: every signal in this block is assigned unconditionally, so no latch
   // is inferred; gating by state happens in the sequential block.
   always_comb begin
      pop_req   = ackWrite & requestWrite;
      push_cand = (|dataReady) && !full;
      pop_cand  = |pop_req;
      take_push = push_cand && (!pop_cand || (last_op == OP_POP));
      push_g    = rr_pick(push_ptr, dataReady);
      pop_g     = rr_pick(pop_ptr, pop_req);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         last_op  <= OP_POP;
         push_ptr <= 2'd3;
         pop_ptr  <= 2'd3;
         count    <= 4'd0;
         ackRead  <= 4'd0;
         popGrant <= 4'd0;
         pushEn   <= 1'b0;
         popEn    <= 1'b0;
         pushData <= '0;
      end else begin
         // NOTE: pulses default low here; a later non-blocking assignment in the
         // same edge overrides it, giving exactly one-cycle strobes.
         ackRead  <= 4'd0;
         popGrant <= 4'd0;
         pushEn   <= 1'b0;
         popEn    <= 1'b0;
         case (state)
            IDLE: begin
               if (take_push) begin
                  state    <= PUSH;
                  push_ptr <= push_g;
                  pushData <= saturate(port_data[push_g]);
                  pushEn   <= 1'b1;
                  ackRead  <= 4'b0001 << push_g;
                  if (pop_cand) last_op <= OP_PUSH;
               end else if (pop_cand) begin
                  state    <= POP;
                  pop_ptr  <= pop_g;
                  popEn    <= 1'b1;
                  popGrant <= 4'b0001 << pop_g;
                  if (push_cand) last_op <= OP_POP;
               end
            end
            PUSH: begin
               state <= IDLE;
               if (count != DEPTH_C) count <= count + 4'd1;
            end
            POP: begin
               state <= IDLE;
               if (count != 4'd0) count <= count - 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(pushEn && popEn));
   a_ack_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(ackRead | popGrant));
   a_count_range: assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);

endmodule

// File: tb/tb_stack_port_arbiter.sv
// Scoreboard bench for stack_port_arbiter: directed pushes/pops with an external
// LIFO model; a negedge monitor compares each strobe against queued expectations.
module tb_stack_port_arbiter;

   localparam int W = 12;

   typedef enum {OP_PUSH, OP_POP} op_e;
   typedef struct {
      op_e op;
      int  port;
      int  value;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] up = '0, down = '0, left = '0, right = '0;
   logic [3:0]   dataReady = 4'd0;
   logic [3:0]   ackWrite = 4'd0;
   logic [3:0]   ackRead, requestWrite, popGrant, count;
   logic [W-1:0] topOut, topData, pushData;
   logic         pushEn, popEn, full, empty;

   logic [W-1:0] mem [0:15];
   int           sp;
   int           checks = 0;
   int           failures = 0;
   exp_t         sb[$];

   stack_port_arbiter dut (
      .clk(clk), .reset(reset),
      .up(up), .down(down), .left(left), .right(right),
      .dataReady(dataReady), .ackRead(ackRead),
      .requestWrite(requestWrite), .ackWrite(ackWrite),
      .popGrant(popGrant), .topOut(topOut), .topData(topData),
      .pushEn(pushEn), .pushData(pushData), .popEn(popEn),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // External LIFO storage
   always @(posedge clk or posedge reset) begin
      if (reset) sp <= 0;
      else if (pushEn) begin
         mem[sp] <= pushData;
         sp      <= sp + 1;
      end else if (popEn) sp <= sp - 1;
   end
   assign topData = (sp > 0) ? mem[sp-1] : '0;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (pushEn || popEn) begin
            check("strobe_excl", int'(pushEn && popEn), 0);
            if (sb.size() == 0) begin
               check("unexpected_strobe", int'(pushEn) + 2 * int'(popEn), 0);
            end else begin
               e = sb.pop_front();
               check("op_kind", int'(popEn), (e.op == OP_POP) ? 1 : 0);
               check("req_write_busy", int'(requestWrite), 0);
               if (e.op == OP_PUSH) begin
                  check("push_ack", int'(ackRead), 1 << e.port);
                  check("push_data", int'($signed(pushData)), e.value);
               end else begin
                  check("pop_grant", int'(popGrant), 1 << e.port);
                  check("pop_top", int'($signed(topOut)), e.value);
               end
            end
         end else if ((ackRead | popGrant) != 4'd0) begin
            check("stray_ack", int'(ackRead | popGrant), 0);
         end
      end
   end

   task automatic set_port(input int p, input int v);
      case (p)
         0: up = W'(v);
         1: down = W'(v);
         2: left = W'(v);
         default: right = W'(v);
      endcase
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      dataReady = 4'd0;
      ackWrite = 4'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_ack(input bit is_pop, input logic [3:0] mask, output int idx, output int cycles);
      logic [3:0] vec;
      idx = -1;
      cycles = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         vec = is_pop ? popGrant : ackRead;
         if ((vec & mask) != 4'd0) begin
            cycles = c;
            for (int i = 0; i < 4; i++) if (vec[i]) idx = i;
            return;
         end
      end
      check(is_pop ? "pop_timeout" : "push_timeout", int'(vec & mask), int'(mask));
   endtask

   task automatic push_one(input int p, input int v, input int exp_v, output int cycles);
      int idx;
      sb.push_back('{OP_PUSH, p, exp_v});
      set_port(p, v);
      dataReady[p] = 1'b1;
      wait_ack(1'b0, 4'b0001 << p, idx, cycles);
      dataReady[p] = 1'b0;
   endtask

   initial begin
      int cyc, idx, n;
      apply_reset();
      check("rst_count", int'(count), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_full", int'(full), 0);
      check("rst_req_write", int'(requestWrite), 0);
      check("rst_strobes", int'({pushEn, popEn, ackRead, popGrant}), 0);
      check("rst_push_data", int'(pushData), 0);

      // Single push and saturation
      push_one(0, 25, 25, cyc);
      check("push_latency", cyc, 1);
      @(negedge clk);
      check("push1_count", int'(count), 1);
      check("push1_req_write", int'(requestWrite), 15);
      check("push1_idle", int'(pushEn), 0);
      push_one(2, 1500, 999, cyc);
      push_one(3, -2000, -999, cyc);
      push_one(1, -999, -999, cyc);
      push_one(0, 999, 999, cyc);
      @(negedge clk);
      check("sat_count", int'(count), 5);

      // Round-robin contention, then fill to full
      apply_reset();
      sb.push_back('{OP_PUSH, 0, 10});
      sb.push_back('{OP_PUSH, 1, -20});
      sb.push_back('{OP_PUSH, 2, 30});
      sb.push_back('{OP_PUSH, 3, 40});
      set_port(0, 10); set_port(1, -20); set_port(2, 30); set_port(3, 40);
      dataReady = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_ack(1'b0, dataReady, idx, cyc);
         if (idx >= 0) dataReady[idx] = 1'b0;
      end
      @(negedge clk);
      check("rr_count", int'(count), 4);
      for (int i = 0; i < 11; i++) push_one(i % 4, 100 + i, 100 + i, cyc);
      @(negedge clk);
      check("fill_count", int'(count), 15);
      check("fill_full", int'(full), 1);
      set_port(0, 77);
      dataReady[0] = 1'b1;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (pushEn || ackRead != 4'd0) n++;
      end
      check("full_blocks_push", n, 0);
      sb.push_back('{OP_POP, 2, 110});
      sb.push_back('{OP_PUSH, 0, 77});
      ackWrite[2] = 1'b1;
      wait_ack(1'b1, 4'b0100, idx, cyc);
      ackWrite = 4'd0;
      wait_ack(1'b0, 4'b0001, idx, cyc);
      dataReady = 4'd0;
      @(negedge clk);
      check("refill_count", int'(count), 15);
      check("refill_full", int'(full), 1);

      // Pop contention and empty behaviour
      apply_reset();
      push_one(0, 5, 5, cyc);
      push_one(1, 6, 6, cyc);
      @(negedge clk);
      check("pop_pre_count", int'(count), 2);
      sb.push_back('{OP_POP, 1, 6});
      sb.push_back('{OP_POP, 3, 5});
      ackWrite = 4'b1010;
      for (int k = 0; k < 2; k++) begin
         wait_ack(1'b1, ackWrite, idx, cyc);
         if (idx >= 0) ackWrite[idx] = 1'b0;
      end
      @(negedge clk);
      check("pop_count", int'(count), 0);
      check("pop_req_write", int'(requestWrite), 0);
      check("pop_empty", int'(empty), 1);
      ackWrite = 4'b1111;
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (popEn || popGrant != 4'd0) n++;
      end
      check("empty_ignores_ackwrite", n, 0);
      ackWrite = 4'd0;

      // Simultaneous push and pop after reset: push wins first
      apply_reset();
      push_one(0, 50, 50, cyc);
      sb.push_back('{OP_PUSH, 0, 60});
      sb.push_back('{OP_POP, 2, 60});
      set_port(0, 60);
      dataReady = 4'b0001;
      ackWrite = 4'b0100;
      for (int c = 0; c < 40 && (dataReady | ackWrite) != 4'd0; c++) begin
         @(negedge clk);
         if (ackRead[0]) dataReady[0] = 1'b0;
         if (popGrant[2]) ackWrite[2] = 1'b0;
      end
      check("mixed_done", int'(dataReady | ackWrite), 0);
      @(negedge clk);
      check("mixed_count", int'(count), 1);

      // Reset during the PUSH cycle
      apply_reset();
      sb.push_back('{OP_PUSH, 1, 33});
      set_port(1, 33);
      dataReady = 4'b0010;
      wait_ack(1'b0, 4'b0010, idx, cyc);
      #2;
      reset = 1'b1;
      dataReady = 4'd0;
      #1;
      check("midrst_ack_read", int'(ackRead), 0);
      check("midrst_push_en", int'(pushEn), 0);
      check("midrst_count", int'(count), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("postrst_count", int'(count), 0);
      check("postrst_empty", int'(empty), 1);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/stack_port_arbiter.md
Name: stack_port_arbiter

Overview:
- Control and arbitration FSM for a 15-entry signed stack node with four neighbour ports: up, down, left, right.
- Accepts pushes from any port with data ready and offers the top-of-stack value to every port ("read ANY, write ANY").
- Grants one operation per transaction using round-robin arbitration.
- Drives an external LIFO storage array through simple push/pop strobes and tracks occupancy, so the storage needs no control logic of its own.

Parameters:
- WIDTH, 12, data width; two's-complement signed.
- DEPTH, 15, maximum stack entries.
- CLAMP, 999, saturation magnitude applied to pushed values.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- up / down / left / right, input, WIDTH each, neighbour write data. Index order: 0=up, 1=down, 2=left, 3=right.
- dataReady, input, 4, neighbour i holds valid write data.
- ackRead, output, 4, one-cycle pulse: data from port i consumed.
- requestWrite, output, 4, stack offers top value to all ports.
- ackWrite, input, 4, neighbour i takes the offered value.
- popGrant, output, 4, one-cycle pulse: port i won the pop.
- topOut, output, WIDTH, broadcast top value (equals topData).
- topData, input, WIDTH, current top entry read combinationally from storage.
- pushEn, output, 1, storage push strobe.
- pushData, output, WIDTH, clamped value to push.
- popEn, output, 1, storage pop strobe.
- count, output, 4, current occupancy, 0..DEPTH.
- full / empty, output, 1 each, count==DEPTH / count==0.

Behaviour:
- **Reset:** async assert forces the following, including mid-transaction; any pending ack is dropped:
  - state=IDLE, count=0, pushPtr=popPtr=3 (first priority goes to up), lastOp=POP.
  - ackRead, popGrant, pushEn and popEn all 0; pushData=0; requestWrite=0; empty=1, full=0.
- **States:** IDLE, PUSH, POP.
- **requestWrite:** all four bits = (state==IDLE && count!=0); identical on every port. topOut=topData continuously.
- **Candidates, evaluated in IDLE only:**
  - pushCand = |dataReady && !full.
  - popCand = |(ackWrite & requestWrite).
- **Op select:**
  - Only pushCand: go to PUSH.
  - Only popCand: go to POP.
  - Both: take the op opposite lastOp, then update lastOp.
- **Round-robin:** search starts at ptr+1 mod 4; the winner becomes the new ptr. Push and pop pointers are independent.
- **IDLE→PUSH at edge N:**
  - Register granted index g.
  - pushData = saturate(port g data, −CLAMP..+CLAMP), signed compare.
  - Cycle N..N+1 (PUSH): pushEn=1, ackRead[g]=1; count increments at the end of this cycle; return to IDLE.
- **IDLE→POP at edge N:**
  - Register granted index g.
  - Cycle in POP: popEn=1, popGrant[g]=1, requestWrite=0; count decrements; return to IDLE.
- **Latency:** request visible in IDLE → strobe and ack in the next cycle → IDLE again one cycle later. Minimum 2 cycles per operation; peak throughput 1 op per 2 cycles.
- **Neighbour obligations:**
  - Push winner must drop dataReady the cycle after ackRead; if it is still high in IDLE, it is treated as a new push.
  - Pop losers keep ackWrite high. They are re-arbitrated when requestWrite returns, with the new top.
- **Full (count==DEPTH):** dataReady is ignored and no ackRead is issued; pops still proceed.
- **Empty:** requestWrite=0 and ackWrite is ignored.
- **Invariants:** count never wraps. pushEn and popEn are never both high. At most one bit of ackRead|popGrant is high at a time.
- **Data sampling:** inputs are sampled only on the IDLE→PUSH edge; later changes to port data do not affect pushData.

Test Plan:
- **Reset then single push:** reset, then dataReady=0001 with up=25 → cycle after sample: pushEn=1, ackRead=0001, pushData=25; next cycle count=1, requestWrite=1111.
- **Saturation:** push left=1500, then right=−2000 → pushData=999, then −999 (12-bit signed).
- **Round-robin contention:** dataReady=1111 held, each port dropping its bit after its ack → grants in order up, down, left, right; count=4.
- **Fill to full:**
  - 15 pushes → full=1, count=15.
  - A 16th push gets no ackRead and no pushEn for 20 cycles.
  - One pop then allows that push to complete; count returns to 15.
- **Pop contention:** count=2, ackWrite=1010 held → popGrant=0010 (down) first, then 1000 (right). popEn pulses twice, count=0, requestWrite=0.
- **Mixed and reset mid-op:**
  - count=1, dataReady=0001 and ackWrite=0100 held together → PUSH first (lastOp=POP after reset), then POP.
  - Asserting reset during the PUSH cycle → ackRead and pushEn drop immediately, count=0.
